prog_seq_ctrl: RTL and testbench

Run controller that sequences the processor's program counter across multiple stored programs. Holds a 4-entry table of program start addresses. On Start, it loads the selected start address into the PC, then enables fetch until the decoder reports a halt instruction. After the halt it drains the pipeline and pulses Done. A watchdog aborts runaway programs. Sits between the top-level test harness and the PC / fetch stage.

---
 rtl/prog_seq_pkg.sv | 8 +
 rtl/prog_addr_table.sv | 25 ++
 rtl/prog_seq_ctrl.sv | 135 +++++++++++++
 tb/tb_prog_seq_ctrl.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/prog_seq_pkg.sv
// Shared types and constants for the program run controller.
package prog_seq_pkg;
  localparam int L_DEF = 10;
  localparam int NPROG = 4;

  typedef enum logic [2:0] {IDLE, LOAD, RUN, DRAIN, DONE} seq_state_t;
  typedef logic [L_DEF-1:0] pc_addr_t;
endpackage

// File: rtl/prog_addr_table.sv
// Start-address register file: NPROG x L entries, write port only live in IDLE,
// combinational read.
module prog_addr_table
  import prog_seq_pkg::*;
#(
  parameter int L = L_DEF
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         i_idle,
  input  logic         i_we,
  input  logic [1:0]   i_widx,
  input  logic [L-1:0] i_wdata,
  input  logic [1:0]   i_ridx,
  output logic [L-1:0] o_rdata
);
  logic [NPROG-1:0][L-1:0] r_tbl;

  always_ff @(posedge Clk) begin
    if (Reset)                r_tbl         <= '0;
    else if (i_we && i_idle)  r_tbl[i_widx] <= i_wdata;
  end

  assign o_rdata = r_tbl[i_ridx];
endmodule

// File: rtl/prog_seq_ctrl.sv
// Program run controller: LOAD -> RUN -> DRAIN -> DONE with watchdog abort.
// Optional macro PROG_STATS_EN adds the RunCycles output.
module prog_seq_ctrl
  import prog_seq_pkg::*;
#(
  parameter int                L         = 10,
  parameter int unsigned       DRAIN_CYC = 2,
  parameter int                WDOG_W    = 16,
  parameter logic [WDOG_W-1:0] WDOG_MAX  = 16'hFFFF
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Start,
  input  logic [1:0]        ProgSel,
  input  logic              CfgWe,
  input  logic [1:0]        CfgIdx,
  input  logic [L-1:0]      CfgAddr,
  input  logic              HaltInsn,
  output logic              PcLoad,
  output logic [L-1:0]      PcLoadAddr,
  output logic              PcEn,
  output logic              Busy,
  output logic              Done,
  output logic              TimeoutErr
`ifdef PROG_STATS_EN
  ,
  output logic [WDOG_W-1:0] RunCycles
`endif
);
  localparam logic [2:0] DRAIN_INIT = 3'(DRAIN_CYC);

  seq_state_t        r_state, w_state_nxt;
  logic [WDOG_W-1:0] r_wdog, w_wdog_nxt;
  logic [2:0]        r_drain, w_drain_nxt;
  logic              r_tmo, w_tmo_nxt;
  logic              r_pc_load, r_pc_en, r_busy, r_done;
  logic [L-1:0]      r_pc_addr;
  logic [L-1:0]      w_tbl_rd;
  logic              w_idle, w_start_acc;

  assign w_idle      = (r_state == IDLE);
  assign w_start_acc = Start && (r_state != DONE);

  // Read happens before this edge's write, so a same-cycle Start sees the old entry.
  prog_addr_table #(.L(L)) u_tbl (
    .Clk     (Clk),
    .Reset   (Reset),
    .i_idle  (w_idle),
    .i_we    (CfgWe),
    .i_widx  (CfgIdx),
    .i_wdata (CfgAddr),
    .i_ridx  (ProgSel),
    .o_rdata (w_tbl_rd)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_wdog_nxt  = r_wdog;
    w_drain_nxt = r_drain;
    w_tmo_nxt   = r_tmo;
    case (r_state)
      IDLE: w_state_nxt = IDLE;
      LOAD: begin
        w_state_nxt = RUN;
        w_wdog_nxt  = '0;
      end
      RUN: begin
        w_wdog_nxt = (&r_wdog) ? r_wdog : r_wdog + 1'b1;
        if (HaltInsn) begin
          w_state_nxt = DRAIN;
          w_drain_nxt = DRAIN_INIT;
        end else if (r_wdog == WDOG_MAX) begin
          w_state_nxt = DONE;
          w_tmo_nxt   = 1'b1;
        end
      end
      DRAIN: begin
        w_drain_nxt = r_drain - 1'b1;
        if (r_drain == 3'd1) w_state_nxt = DONE;
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
    // An accepted Start restarts from LOAD in any state but DONE.
    if (w_start_acc) begin
      w_state_nxt = LOAD;
      w_wdog_nxt  = '0;
      w_tmo_nxt   = 1'b0;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state   <= IDLE;
      r_wdog    <= '0;
      r_drain   <= '0;
      r_tmo     <= 1'b0;
      r_pc_load <= 1'b0;
      r_pc_addr <= '0;
      r_pc_en   <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_wdog    <= w_wdog_nxt;
      r_drain   <= w_drain_nxt;
      r_tmo     <= w_tmo_nxt;
      r_pc_load <= (w_state_nxt == LOAD);
      r_pc_addr <= (w_state_nxt == LOAD) ? w_tbl_rd : '0;
      r_pc_en   <= (w_state_nxt == RUN);
      r_busy    <= (w_state_nxt == LOAD) || (w_state_nxt == RUN) || (w_state_nxt == DRAIN);
      r_done    <= (w_state_nxt == DONE);
    end
  end

  assign PcLoad     = r_pc_load;
  assign PcLoadAddr = r_pc_addr;
  assign PcEn       = r_pc_en;
  assign Busy       = r_busy;
  assign Done       = r_done;
  assign TimeoutErr = r_tmo;

`ifdef PROG_STATS_EN
  logic [WDOG_W-1:0] r_run_cycles;

  always_ff @(posedge Clk) begin
    if (Reset)
      r_run_cycles <= '0;
    else if (w_state_nxt == DONE && r_state != DONE)
      r_run_cycles <= w_wdog_nxt;
  end

  assign RunCycles = r_run_cycles;
`endif
endmodule

// File: tb/tb_prog_seq_ctrl.sv
// Self-checking bench for prog_seq_ctrl: directed vector table, hand-written
// corner sequences and randomized traffic against a behavioural model.
module tb_prog_seq_ctrl;
  localparam int L     = 10;
  localparam int DRAIN = 2;
  localparam int WW    = 16;
  localparam int WMAX  = 8;

  logic          Clk = 1'b0;
  logic          Reset, Start, CfgWe, HaltInsn;
  logic [1:0]    ProgSel, CfgIdx;
  logic [L-1:0]  CfgAddr, PcLoadAddr;
  logic          PcLoad, PcEn, Busy, Done, TimeoutErr;
`ifdef PROG_STATS_EN
  logic [WW-1:0] RunCycles;
`endif

  always #5 Clk = ~Clk;

  prog_seq_ctrl #(.L(L), .DRAIN_CYC(DRAIN), .WDOG_W(WW), .WDOG_MAX(16'(WMAX))) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .Start      (Start),
    .ProgSel    (ProgSel),
    .CfgWe      (CfgWe),
    .CfgIdx     (CfgIdx),
    .CfgAddr    (CfgAddr),
    .HaltInsn   (HaltInsn),
    .PcLoad     (PcLoad),
    .PcLoadAddr (PcLoadAddr),
    .PcEn       (PcEn),
    .Busy       (Busy),
    .Done       (Done),
`ifdef PROG_STATS_EN
    .RunCycles  (RunCycles),
`endif
    .TimeoutErr (TimeoutErr)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Behavioural model: a run is a sequence of phases with counted lengths.
  int m_tbl [4];
  bit m_ld, m_run, m_done, m_tmo;
  int m_drain, m_runs, m_addr, m_stats;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_step(input bit rst, input bit st, input logic [1:0] ps, input bit we,
                            input logic [1:0] ci, input logic [L-1:0] ca, input bit h);
    int  sel_addr;
    bit  idle;
    if (rst) begin
      foreach (m_tbl[i]) m_tbl[i] = 0;
      m_ld = 0; m_run = 0; m_done = 0; m_tmo = 0;
      m_drain = 0; m_runs = 0; m_addr = 0; m_stats = 0;
      return;
    end
    idle     = !(m_ld || m_run || m_drain > 0 || m_done);
    sel_addr = m_tbl[ps];
    if (we && idle) m_tbl[ci] = int'(ca);
    if (st && !m_done) begin
      m_ld = 1; m_addr = sel_addr; m_run = 0; m_drain = 0; m_tmo = 0; m_runs = 0;
    end else if (m_ld) begin
      m_ld = 0; m_run = 1; m_runs = 0;
    end else if (m_run) begin
      // m_runs = RUN cycles completed before this one (the watchdog reading)
      if (h) begin
        m_run = 0; m_drain = DRAIN;
      end else if (m_runs == WMAX) begin
        m_run = 0; m_done = 1; m_tmo = 1;
      end
      m_runs = (m_runs < (1 << WW) - 1) ? m_runs + 1 : m_runs;
      if (m_done) m_stats = m_runs;
    end else if (m_drain > 0) begin
      m_drain--;
      if (m_drain == 0) begin m_done = 1; m_stats = m_runs; end
    end else if (m_done) begin
      m_done = 0;
    end
  endtask

  task automatic chk_model();
    chk("PcLoad", PcLoad, m_ld);
    if (m_ld) chk("PcLoadAddr", PcLoadAddr, m_addr);
    chk("PcEn", PcEn, m_run);
    chk("Busy", Busy, m_ld || m_run || m_drain > 0);
    chk("Done", Done, m_done);
    chk("TimeoutErr", TimeoutErr, m_tmo);
`ifdef PROG_STATS_EN
    chk("RunCycles", RunCycles, m_stats);
`endif
  endtask

  task automatic cyc(input bit rst, input bit st, input logic [1:0] ps, input bit we,
                     input logic [1:0] ci, input logic [L-1:0] ca, input bit h);
    Reset = rst; Start = st; ProgSel = ps; CfgWe = we; CfgIdx = ci; CfgAddr = ca; HaltInsn = h;
    model_step(rst, st, ps, we, ci, ca, h);
    @(posedge Clk); #1;
    chk_model();
  endtask

  task automatic idle();
    cyc(0, 0, 2'd0, 0, 2'd0, '0, 0);
  endtask

  task automatic run_to_idle(input string nm, output int nd);
    bit ok = 0;
    nd = 0;
    for (int i = 0; i < 30 && !ok; i++) begin
      idle();
      if (Done) nd++;
      if (!Busy && !Done) ok = 1;
    end
    chk({nm, "_reached_idle"}, ok, 1);
  endtask

  typedef struct {
    bit st; logic [1:0] ps; bit we; logic [1:0] ci; logic [L-1:0] ca; bit h;
    bit e_ld; logic [L-1:0] e_addr; bit e_en, e_busy, e_done, e_tmo;
  } vec_t;

  function automatic vec_t v(input bit st, input int ps, input bit we, input int ci, input int ca,
                             input bit h, input bit eld, input int eaddr, input bit een,
                             input bit ebusy, input bit edone, input bit etmo);
    vec_t r;
    r.st = st; r.ps = 2'(ps); r.we = we; r.ci = 2'(ci); r.ca = L'(ca); r.h = h;
    r.e_ld = eld; r.e_addr = L'(eaddr); r.e_en = een; r.e_busy = ebusy; r.e_done = edone;
    r.e_tmo = etmo;
    return r;
  endfunction

  vec_t vt[$];
  int   nrun, ndone, nd;
  bit   seen, prev_en;

  initial begin
    Reset = 1; Start = 0; ProgSel = 0; CfgWe = 0; CfgIdx = 0; CfgAddr = 0; HaltInsn = 0;
    cyc(1, 0, 2'd0, 0, 2'd0, '0, 0);
    cyc(1, 0, 2'd0, 0, 2'd0, '0, 0);
    chk("rst_PcLoad", PcLoad, 0);
    chk("rst_PcLoadAddr", PcLoadAddr, 0);
    chk("rst_PcEn", PcEn, 0);
    chk("rst_Busy", Busy, 0);
    chk("rst_Done", Done, 0);
    chk("rst_TimeoutErr", TimeoutErr, 0);

    // Program 1 at 0x040, halt in the 5th RUN cycle, 2-cycle drain, Done, IDLE.
    vt.push_back(v(0, 0, 1, 1, 'h040, 0,  0, 0,     0, 0, 0, 0));
    vt.push_back(v(1, 1, 0, 0, 0,     0,  1, 'h040, 0, 1, 0, 0));
    for (int i = 0; i < 5; i++)
      vt.push_back(v(0, 0, 0, 0, 0,   0,  0, 0,     1, 1, 0, 0));
    vt.push_back(v(0, 0, 0, 0, 0,     1,  0, 0,     0, 1, 0, 0));
    vt.push_back(v(0, 0, 0, 0, 0,     0,  0, 0,     0, 1, 0, 0));
    vt.push_back(v(0, 0, 0, 0, 0,     0,  0, 0,     0, 0, 1, 0));
    vt.push_back(v(0, 0, 0, 0, 0,     1,  0, 0,     0, 0, 0, 0));
    vt.push_back(v(0, 0, 0, 0, 0,     1,  0, 0,     0, 0, 0, 0));
    foreach (vt[i]) begin
      cyc(0, vt[i].st, vt[i].ps, vt[i].we, vt[i].ci, vt[i].ca, vt[i].h);
      chk($sformatf("vec%0d_PcLoad", i), PcLoad, vt[i].e_ld);
      if (vt[i].e_ld) chk($sformatf("vec%0d_PcLoadAddr", i), PcLoadAddr, vt[i].e_addr);
      chk($sformatf("vec%0d_PcEn", i), PcEn, vt[i].e_en);
      chk($sformatf("vec%0d_Busy", i), Busy, vt[i].e_busy);
      chk($sformatf("vec%0d_Done", i), Done, vt[i].e_done);
      chk($sformatf("vec%0d_TimeoutErr", i), TimeoutErr, vt[i].e_tmo);
    end
`ifdef PROG_STATS_EN
    chk("stats_halt_run", RunCycles, 5);
`endif

    // Watchdog: reads WMAX during the (WMAX+1)th RUN cycle, then DONE with no drain.
    cyc(0, 1, 2'd0, 0, 2'd0, '0, 0);
    nrun = 0; seen = 0; prev_en = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      idle();
      if (PcEn) nrun++;
      if (Done) begin
        seen = 1;
        chk("tmo_set_with_done", TimeoutErr, 1);
        chk("tmo_no_drain", prev_en, 1);
      end
      prev_en = PcEn;
    end
    chk("tmo_done_seen", seen, 1);
    chk("tmo_run_cycles", nrun, WMAX + 1);
`ifdef PROG_STATS_EN
    chk("stats_tmo_run", RunCycles, WMAX + 1);
`endif
    idle();
    chk("tmo_sticky_idle", TimeoutErr, 1);

    // Abort-and-restart into program 2; a RUN-time table write must be dropped.
    cyc(0, 0, 2'd0, 1, 2'd2, 10'h2A0, 0);
    cyc(0, 1, 2'd0, 0, 2'd0, '0, 0);
    chk("tmo_cleared_by_start", TimeoutErr, 0);
    ndone = 0;
    for (int i = 0; i < 3; i++) begin idle(); ndone += int'(Done); end
    cyc(0, 0, 2'd0, 1, 2'd2, 10'h3FF, 0);
    ndone += int'(Done);
    cyc(0, 1, 2'd2, 0, 2'd0, '0, 0);
    chk("abort_PcLoad", PcLoad, 1);
    chk("abort_PcLoadAddr", PcLoadAddr, 10'h2A0);
    idle(); idle();
    cyc(0, 0, 2'd0, 0, 2'd0, '0, 1);
    run_to_idle("abort", nd);
    chk("abort_done_pulses", ndone + nd, 1);
    cyc(0, 1, 2'd2, 0, 2'd0, '0, 0);
    chk("run_write_dropped", PcLoadAddr, 10'h2A0);
    idle();
    cyc(0, 0, 2'd0, 0, 2'd0, '0, 1);
    run_to_idle("readback", nd);

    // Start and CfgWe to the same entry in one IDLE cycle: old value used.
    cyc(0, 1, 2'd3, 1, 2'd3, 10'h100, 0);
    chk("same_cycle_old_addr", PcLoadAddr, 0);
    idle();
    cyc(0, 0, 2'd0, 0, 2'd0, '0, 1);
    run_to_idle("same_cycle", nd);
    cyc(0, 1, 2'd3, 0, 2'd0, '0, 0);
    chk("same_cycle_new_addr", PcLoadAddr, 10'h100);

    // Reset in the middle of DRAIN.
    idle(); idle();
    cyc(0, 0, 2'd0, 0, 2'd0, '0, 1);
    chk("pre_reset_in_drain", Busy && !PcEn, 1);
    cyc(1, 0, 2'd0, 0, 2'd0, '0, 0);
    chk("mid_rst_PcEn", PcEn, 0);
    chk("mid_rst_Busy", Busy, 0);
    chk("mid_rst_Done", Done, 0);
    chk("mid_rst_PcLoad", PcLoad, 0);
`ifdef PROG_STATS_EN
    chk("mid_rst_RunCycles", RunCycles, 0);
`endif
    cyc(0, 0, 2'd0, 0, 2'd0, '0, 1);
    cyc(0, 0, 2'd0, 0, 2'd0, '0, 1);
    chk("idle_halt_ignored", Busy || PcEn || Done, 0);
    cyc(0, 1, 2'd1, 0, 2'd0, '0, 0);
    chk("table_cleared", PcLoadAddr, 0);

    // Randomized traffic checked every cycle against the model.
    for (int i = 0; i < 3000; i++)
      cyc($urandom_range(0, 99) == 0, $urandom_range(0, 11) == 0, 2'($urandom),
          $urandom_range(0, 4) == 0, 2'($urandom), L'($urandom), $urandom_range(0, 6) == 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
